// File: rtl/burst_stream_arbiter.sv
// N-to-1 valid/ready arbiter with optional burst lock and an output FIFO
// that tags every queued beat with the index of the stream it came from.
//
// state     | meaning
// ST_OPEN   | no burst in flight, grant follows the arbitration policy
// ST_LOCKED | burst in flight, grant pinned to lock_id until its last beat
module burst_stream_arbiter #(
  parameter int COUNT       = 2,
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 2,
  parameter int ROUND_ROBIN = 1,
  parameter int LOCK_BURST  = 1,
  localparam int ID_W       = (COUNT > 1) ? $clog2(COUNT) : 1,
  localparam int LVL_W      = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [COUNT-1:0]       in_valid,
  output logic [COUNT-1:0]       in_ready,
  input  logic [COUNT*WIDTH-1:0] in_payload,
  input  logic [COUNT-1:0]       in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_payload,
  output logic                   out_last,
  output logic [ID_W-1:0]        out_id,
  output logic [LVL_W-1:0]       level
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_t;

  lock_state_t      state;
  logic [ID_W-1:0]  lock_id;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  pr_grant;
  logic [ID_W-1:0]  rr_grant;
  logic [ID_W-1:0]  grant;
  int               best_dist;
  int               cand_dist;

  logic             sel_valid;
  logic             sel_last;
  logic [WIDTH-1:0] sel_payload;
  logic             space;
  logic             accept;
  logic             pop;

  logic [WIDTH-1:0] mem_payload [DEPTH];
  logic             mem_last    [DEPTH];
  logic [ID_W-1:0]  mem_id      [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    pr_grant = '0;
    for (int i = COUNT - 1; i >= 0; i--) begin
      if (in_valid[i]) pr_grant = ID_W'(i);
    end
  end

  // Round-robin: the valid stream closest after ptr (wrapping) wins.
  always_comb begin
    rr_grant  = ptr;
    best_dist = COUNT;
    cand_dist = 0;
    for (int i = 0; i < COUNT; i++) begin
      cand_dist = (i + COUNT - int'(ptr) - 1) % COUNT;
      if (in_valid[i] && (cand_dist < best_dist)) begin
        best_dist = cand_dist;
        rr_grant  = ID_W'(i);
      end
    end
  end

  always_comb begin
    if (state == ST_LOCKED) grant = lock_id;
    else if (ROUND_ROBIN != 0) grant = rr_grant;
    else grant = pr_grant;
  end

  always_comb begin
    sel_valid   = 1'b0;
    sel_last    = 1'b0;
    sel_payload = '0;
    for (int i = 0; i < COUNT; i++) begin
      if (grant == ID_W'(i)) begin
        sel_valid   = in_valid[i];
        sel_last    = in_last[i];
        sel_payload = in_payload[i*WIDTH +: WIDTH];
      end
    end
  end

  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready;
  // While in reset the FIFO is treated as empty, so the granted stream sees space.
  assign space     = !rst_n || (level < LVL_W'(DEPTH)) || pop;
  assign accept    = sel_valid && space;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < COUNT; i++) begin
      in_ready[i] = space && (grant == ID_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_OPEN;
      lock_id <= '0;
      ptr     <= ID_W'(COUNT - 1);
    end else if (accept) begin
      if ((LOCK_BURST != 0) && !sel_last) begin
        state   <= ST_LOCKED;
        lock_id <= grant;
      end else begin
        state <= ST_OPEN;
      end
      if ((ROUND_ROBIN != 0) && (sel_last || (LOCK_BURST == 0))) ptr <= grant;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_payload[i] <= '0;
        mem_last[i]    <= 1'b0;
        mem_id[i]      <= '0;
      end
    end else begin
      if (accept) begin
        mem_payload[wr_ptr] <= sel_payload;
        mem_last[wr_ptr]    <= sel_last;
        mem_id[wr_ptr]      <= grant;
        wr_ptr              <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      if (accept && !pop) level <= level + LVL_W'(1);
      else if (!accept && pop) level <= level - LVL_W'(1);
    end
  end

  assign out_payload = mem_payload[rd_ptr];
  assign out_last    = mem_last[rd_ptr];
  assign out_id      = mem_id[rd_ptr];

endmodule
